// File: rtl/oled_spi_ctrl.sv
// Reset/init sequencer and byte-wide SPI (mode 0) master for two OLED panels on one bus.
// Latency: one accept cycle after the handshake, then SETUP + 8 bits + GAP; byte period is 18*CLK_DIV+2.
// Backpressure: o_Ready is high only in IDLE. Requests offered while it is low wait until it rises.
// Optional init ROM sequence is built only when OLED_SPI_CTRL_INIT_EN is defined.
module oled_spi_ctrl #(
   parameter int CLK_DIV       = 4,
   parameter int RST_PULSE_CYC = 500,
   parameter int RST_WAIT_CYC  = 5000
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic       i_Valid,
   input  logic [7:0] i_Data,
   input  logic       i_DC,
   input  logic [1:0] i_Sel,
   output logic       o_Ready,
   output logic       o_Done,
   output logic       o_InitDone,
   output logic       o_Res,
   output logic       o_CS1_n,
   output logic       o_CS2_n,
   output logic       o_DC,
   output logic       o_D0,
   output logic       o_D1
);

   localparam int CNT_MAX0 = (RST_PULSE_CYC > RST_WAIT_CYC) ? RST_PULSE_CYC : RST_WAIT_CYC;
   localparam int CNT_MAX  = (CNT_MAX0 > CLK_DIV) ? CNT_MAX0 : CLK_DIV;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RST_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_RST_LOW, S_RST_WAIT, S_IDLE, S_ACCEPT, S_SETUP, S_SHIFT, S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic             sclk_q, sclk_d;
   logic [7:0]       sh_q, sh_d;     // byte being shifted, current bit in [7]
   logic             dcc_q, dcc_d;   // DC captured at accept, driven at SETUP
   logic             dc_q, dc_d;     // DC pin, holds while CS is high
   logic             d1_q, d1_d;     // MOSI pin, holds while CS is high
   logic [1:0]       sel_q, sel_d;
   logic             idone_q, idone_d;
   logic             rom_phase;      // current byte comes from the init ROM

`ifdef OLED_SPI_CTRL_INIT_EN
   logic       init_q, init_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] rom_b;

   function automatic logic [7:0] rom_byte(input logic [2:0] i);
      case (i)
         3'd0:    rom_byte = 8'hAE;
         3'd1:    rom_byte = 8'hD5;
         3'd2:    rom_byte = 8'h80;
         3'd3:    rom_byte = 8'hA8;
         3'd4:    rom_byte = 8'h3F;
         3'd5:    rom_byte = 8'h8D;
         3'd6:    rom_byte = 8'h14;
         default: rom_byte = 8'hAF;
      endcase
   endfunction

   assign rom_phase = init_q;
`else
   assign rom_phase = 1'b0;
`endif

   // State and datapath registers; reset aborts any byte in flight.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= S_RST_LOW;
         cnt_q   <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'b0;
         sh_q    <= '0;
         dcc_q   <= 1'b0;
         dc_q    <= 1'b0;
         d1_q    <= 1'b0;
         sel_q   <= '0;
         idone_q <= 1'b0;
`ifdef OLED_SPI_CTRL_INIT_EN
         init_q  <= 1'b0;
         idx_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
         sh_q    <= sh_d;
         dcc_q   <= dcc_d;
         dc_q    <= dc_d;
         d1_q    <= d1_d;
         sel_q   <= sel_d;
         idone_q <= idone_d;
`ifdef OLED_SPI_CTRL_INIT_EN
         init_q  <= init_d;
         idx_q   <= idx_d;
`endif
      end
   end

   // Next-state logic: reset pulse, wait, ROM bytes, then user bytes with SPI timing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sclk_d  = sclk_q;
      sh_d    = sh_q;
      dcc_d   = dcc_q;
      dc_d    = dc_q;
      d1_d    = d1_q;
      sel_d   = sel_q;
      idone_d = idone_q;
`ifdef OLED_SPI_CTRL_INIT_EN
      init_d  = init_q;
      idx_d   = idx_q;
      rom_b   = rom_byte((state_q == S_GAP) ? idx_q + 3'd1 : 3'd0);
`endif
      case (state_q)
         S_RST_LOW: begin
            if (cnt_q == PULSE_LAST) begin
               cnt_d   = '0;
               state_d = S_RST_WAIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RST_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d = '0;
`ifdef OLED_SPI_CTRL_INIT_EN
               // First ROM byte goes straight to SETUP so CS falls exactly
               // RST_WAIT_CYC cycles after the panel leaves reset.
               init_d  = 1'b1;
               idx_d   = 3'd0;
               sh_d    = rom_b;
               d1_d    = rom_b[7];
               dc_d    = 1'b0;
               sel_d   = 2'b11;
               state_d = S_SETUP;
`else
               idone_d = 1'b1;
               state_d = S_IDLE;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (i_Valid) begin
               sh_d    = i_Data;
               dcc_d   = i_DC;
               sel_d   = i_Sel;
               state_d = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            cnt_d = '0;
            if (sel_q == 2'b00) begin
               state_d = S_IDLE;   // no panel selected: drop the byte, o_Done still pulses
            end else begin
               dc_d    = dcc_q;
               d1_d    = sh_q[7];
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               sclk_d  = 1'b1;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d = '0;
               if (sclk_q) begin
                  // Falling edge: present the next bit; the last bit is held.
                  sclk_d = 1'b0;
                  if (bit_q != 3'd7) begin
                     d1_d = sh_q[6];
                     sh_d = {sh_q[6:0], 1'b0};
                  end
               end else if (bit_q == 3'd7) begin
                  state_d = S_GAP;
               end else begin
                  bit_d  = bit_q + 1'b1;
                  sclk_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
`ifdef OLED_SPI_CTRL_INIT_EN
               if (init_q) begin
                  if (idx_q == 3'd7) begin
                     init_d  = 1'b0;
                     idone_d = 1'b1;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     sh_d    = rom_b;
                     d1_d    = rom_b[7];
                     dc_d    = 1'b0;
                     sel_d   = 2'b11;
                     state_d = S_SETUP;
                  end
               end
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_RST_LOW;
      endcase
   end

   assign o_Ready    = (state_q == S_IDLE);
   assign o_Done     = ((state_q == S_ACCEPT) && (sel_q == 2'b00)) ||
                       ((state_q == S_GAP) && (cnt_q == '0) && !rom_phase);
   assign o_InitDone = idone_q;
   assign o_Res      = (state_q != S_RST_LOW);
   assign o_CS1_n    = !(((state_q == S_SETUP) || (state_q == S_SHIFT)) && sel_q[0]);
   assign o_CS2_n    = !(((state_q == S_SETUP) || (state_q == S_SHIFT)) && sel_q[1]);
   assign o_DC       = dc_q;
   assign o_D0       = sclk_q;
   assign o_D1       = d1_q;

endmodule

// File: tb/tb_oled_spi_ctrl.sv
// Directed bench for oled_spi_ctrl with CLK_DIV=2, RST_PULSE_CYC=4, RST_WAIT_CYC=4.
// Latency: outputs are sampled 1 ns after each rising clock edge.
// Backpressure: requests wait on o_Ready with a bounded cycle budget.
module tb_oled_spi_ctrl;

   logic       clk;
   logic       rst_n;
   logic       i_valid;
   logic [7:0] i_data;
   logic       i_dc;
   logic [1:0] i_sel;
   logic       o_ready, o_done, o_initdone, o_res, o_cs1_n, o_cs2_n, o_dc, o_d0, o_d1;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int acc_n = 0;
   int acc_last = 0;
   int acc_prev = 0;

   logic [7:0] rom_exp [8] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'h8D, 8'h14, 8'hAF};

   oled_spi_ctrl #(.CLK_DIV(2), .RST_PULSE_CYC(4), .RST_WAIT_CYC(4)) dut (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(i_valid), .i_Data(i_data), .i_DC(i_dc),
      .i_Sel(i_sel), .o_Ready(o_ready), .o_Done(o_done), .o_InitDone(o_initdone),
      .o_Res(o_res), .o_CS1_n(o_cs1_n), .o_CS2_n(o_cs2_n), .o_DC(o_dc), .o_D0(o_d0), .o_D1(o_d1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log each handshake (seen mid-cycle; it completes on the next rising edge).
   always @(negedge clk) begin
      if (rst_n && o_ready && i_valid) begin
         acc_n    <= acc_n + 1;
         acc_prev <= acc_last;
         acc_last <= cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s observed=timeout expected=event", tag);
   endtask

   task automatic wait_ready();
      for (int n = 0; n < 200; n++) begin
         if (o_ready) return;
         tick();
      end
      timeout("wait_ready");
   endtask

   // Follow one CS-low window from the current sample point; returns on the
   // first sample with CS high again (first GAP cycle).
   task automatic xfer(output logic [7:0] b, output int lo, output int rises, output int pre_hi,
                       output logic c1, output logic c2, output int dones, output int dc1,
                       output int bad);
      logic started = 1'b0;
      logic prev    = o_d0;
      b = '0; lo = 0; rises = 0; pre_hi = 0; c1 = 1'b0; c2 = 1'b0; dones = 0; dc1 = 0; bad = 0;
      for (int n = 0; n < 300; n++) begin
         if (o_cs1_n && o_cs2_n) begin
            if (o_d0) bad++;
            if (started) begin
               if (o_done) dones++;
               return;
            end
            pre_hi++;
         end else begin
            started = 1'b1;
            lo++;
            if (!o_cs1_n) c1 = 1'b1;
            if (!o_cs2_n) c2 = 1'b1;
            if (o_dc) dc1++;
            if (o_done) dones++;
            if (o_d0 && !prev) begin
               rises++;
               b = {b[6:0], o_d1};
            end
         end
         prev = o_d0;
         tick();
      end
      timeout("xfer");
   endtask

   // Release reset and check the pulse, wait and (optional) init sequence.
   task automatic boot_check(input string tag);
      logic [7:0] b;
      int lo, rises, pre_hi, dones, dc1, bad;
      logic c1, c2;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 3 || k == 4) chk({tag, "_res"}, o_res, (k >= 4));
`ifdef OLED_SPI_CTRL_INIT_EN
         if (k == 7 || k == 8) chk({tag, "_cs1"}, o_cs1_n, (k < 8));
         if (k == 8) begin
            chk({tag, "_cs2"}, o_cs2_n, 1'b0);
            chk({tag, "_dc"},  o_dc,    1'b0);
            chk({tag, "_rdy"}, o_ready, 1'b0);
         end
`else
         if (k == 7 || k == 8) begin
            chk({tag, "_rdy"},   o_ready,    (k == 8));
            chk({tag, "_idone"}, o_initdone, (k == 8));
         end
`endif
      end
`ifdef OLED_SPI_CTRL_INIT_EN
      for (int k = 0; k < 8; k++) begin
         xfer(b, lo, rises, pre_hi, c1, c2, dones, dc1, bad);
         chk({tag, "_rom"},    b,           rom_exp[k]);
         chk({tag, "_rom_cs"}, {c1, c2},    2'b11);
         chk({tag, "_rom_lo"}, lo,          34);
         chk({tag, "_rom_dc"}, dc1,         0);
         chk({tag, "_rom_dn"}, dones,       0);
      end
      tick();
      chk({tag, "_idone_gap"}, o_initdone, 1'b0);
      tick();
      chk({tag, "_idone"}, o_initdone, 1'b1);
      chk({tag, "_rdy"},   o_ready,    1'b1);
`else
      for (int k = 0; k < 4; k++) begin
         tick();
         chk({tag, "_quiet"}, {o_d0, o_cs1_n, o_cs2_n}, 3'b011);
      end
`endif
   endtask

   initial begin
      logic [7:0] b;
      int lo, rises, pre_hi, dones, dc1, bad, acc0, r;
      logic c1, c2, prev;
      rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_dc = 1'b0; i_sel = '0;

      #2;
      chk("reset_pins", {o_res, o_cs1_n, o_cs2_n, o_dc, o_d0, o_d1}, 6'b011000);
      chk("reset_flags", {o_ready, o_done, o_initdone}, 3'b000);

      // Test 1 / 6: boot sequence.
      boot_check("boot");

      // Test 2: single byte to panel 1.
      wait_ready();
      i_valid = 1'b1; i_data = 8'hA5; i_dc = 1'b1; i_sel = 2'b01;
      tick();
      i_valid = 1'b0;
      chk("t2_rdy_drop", o_ready, 1'b0);
      xfer(b, lo, rises, pre_hi, c1, c2, dones, dc1, bad);
      chk("t2_byte",  b,        8'hA5);
      chk("t2_lo",    lo,       34);
      chk("t2_rises", rises,    8);
      chk("t2_cs",    {c1, c2}, 2'b10);
      chk("t2_dc",    dc1,      34);
      chk("t2_done",  dones,    1);
      chk("t2_sclk",  bad,      0);

      // Test 3: back-to-back requests to panel 2 with valid held high.
      wait_ready();
      acc0 = acc_n;
      i_valid = 1'b1; i_data = 8'h01; i_dc = 1'b1; i_sel = 2'b10;
      tick();
      i_data = 8'h80;
      xfer(b, lo, rises, pre_hi, c1, c2, dones, dc1, bad);
      chk("t3_byte1", b,        8'h01);
      chk("t3_cs1",   {c1, c2}, 2'b01);
      chk("t3_done1", dones,    1);
      xfer(b, lo, rises, pre_hi, c1, c2, dones, dc1, bad);
      i_valid = 1'b0;
      chk("t3_byte2",  b,        8'h80);
      chk("t3_cs2",    {c1, c2}, 2'b01);
      chk("t3_gap",    pre_hi,   4);
      chk("t3_sclk",   bad,      0);
      chk("t3_accn",   acc_n - acc0,        2);
      chk("t3_period", acc_last - acc_prev, 38);

      // Test 4: no panel selected.
      wait_ready();
      i_valid = 1'b1; i_data = 8'hFF; i_dc = 1'b0; i_sel = 2'b00;
      tick();
      i_valid = 1'b0;
      chk("t4_done",  o_done,  1'b1);
      chk("t4_rdy0",  o_ready, 1'b0);
      chk("t4_pins0", {o_cs1_n, o_cs2_n, o_d0}, 3'b110);
      tick();
      chk("t4_done0", o_done,  1'b0);
      chk("t4_rdy1",  o_ready, 1'b1);
      chk("t4_hold",  {o_cs1_n, o_cs2_n, o_d0, o_dc, o_d1}, 5'b11010);

      // Test 5: reset in the middle of a byte.
      wait_ready();
      i_valid = 1'b1; i_data = 8'hC3; i_dc = 1'b0; i_sel = 2'b11;
      tick();
      i_valid = 1'b0;
      r = 0;
      prev = o_d0;
      for (int n = 0; n < 100 && r < 3; n++) begin
         tick();
         if (o_d0 && !prev) r++;
         prev = o_d0;
      end
      chk("t5_rises", r, 3);
      rst_n = 1'b0;
      #1;
      chk("t5_pins",  {o_res, o_cs1_n, o_cs2_n, o_d0}, 4'b0110);
      chk("t5_flags", {o_ready, o_initdone, o_done},  3'b000);
      tick();
      tick();
      chk("t5_nodone", o_done, 1'b0);
      boot_check("reboot");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
